plugboard_mapper: RTL and testbench
===================================

// Module: plugboard_mapper
// PURPOSE
//   Stateful Enigma plugboard: stores up to MAX_PAIRS letter swaps and serves lookups.
//   Programming side accepts letters one at a time over a valid/ready handshake; two accepted letters form one pair.
//   Lookup side provides two independent registered lookups. front_* serves keyboard -> rotors. rear_* serves rotors/reflector -> lamp/gui.
//   Letters are one-hot 26-bit vectors; bit 0 = 'A', bit 25 = 'Z'.
// PARAMETERS
//   N_LETTERS  26  alphabet size / one-hot width
//   MAX_PAIRS  10  maximum stored plug pairs
// PORTS
//   CLOCK_50        in   1   single clock, all state on rising edge
//   reset           in   1   asynchronous, active-high reset
//   prog_valid      in   1   prog_letter is offered
//   prog_letter     in   26  one-hot letter to plug
//   prog_ready      out  1   mapper can accept a letter this cycle
//   prog_clear      in   1   synchronous clear of all pairs
//   prog_error      out  1   one-cycle pulse: offered letter rejected
//   pair_count      out  4   number of committed pairs (0..MAX_PAIRS)
//   front_valid     in   1   front_in lookup request
//   front_in        in   26  one-hot letter from keyboard
//   front_out_valid out  1   front_out valid
//   front_out       out  26  swapped letter to rotors
//   rear_valid      in   1   rear_in lookup request
//   rear_in         in   26  one-hot letter from rotor/reflector path
//   rear_out_valid  out  1   rear_out valid
//   rear_out        out  26  swapped letter to display
// BEHAVIOUR
//   Reset (async): table empty (identity), pair_count=0, FSM=P_FIRST, prog_error=0, all *_out and *_out_valid=0.
//   Table: partner[26] (5-bit index) + plugged[26] mask. Unplugged letters map to themselves.
//   Programming FSM:
//     - P_FIRST: prog_ready=1. On accept of a valid letter, latch it as first, go to P_SECOND.
//     - P_SECOND: prog_ready=1. On accept of a valid letter:
//       partner[a]=b, partner[b]=a; set plugged a,b; pair_count+1.
//       Next state is P_FULL if pair_count reaches MAX_PAIRS, else P_FIRST.
//     - P_FULL: prog_ready=0. prog_valid is ignored (no error).
//   Accept = prog_valid & prog_ready.
//   A letter is rejected on accept if any of these hold:
//     - it is not one-hot (zero bits or more than one bit);
//     - it is already plugged;
//     - in P_SECOND only, it equals the latched first letter.
//   On rejection: prog_error=1 the next cycle, the latched first letter is discarded, FSM goes to P_FIRST. The table is unchanged.
//   prog_clear, from any state: next cycle table is identity, pair_count=0, FSM=P_FIRST.
//     It wins over a simultaneous prog_valid; that letter is dropped with no error.
//   Lookups:
//     - Latency 1: *_out_valid <= *_valid and *_out <= swap(*_in) on each edge.
//     - *_out holds its last value when *_valid=0.
//     - A non-one-hot *_in yields *_out=26'b0, with *_out_valid still asserted.
//     - front and rear may both be requested in the same cycle; they do not interact.
//   A lookup issued in the same cycle as a commit or clear uses the pre-edge (old) table. The new mapping is visible one cycle later.
//   No combinational path from any input to any output except prog_ready, which depends on FSM state only.
// STRUCTURE
//   Shared package enigma_pkg holds N_LETTERS, letter_oh_t (26-bit), letter_idx_t (5-bit), and functions is_onehot(), oh2idx(), idx2oh().
//   Sub-module letter_swap (combinational: one-hot in + partner/plugged table -> one-hot out) is instantiated twice, once for front and once for rear.
//   This block contains the programming FSM, the table, the counter and the output registers.
// TESTING
//   1. Reset, front_in=26'h1 with front_valid -> next cycle front_out=26'h1, front_out_valid=1, pair_count=0.
//   2. Program A(26'h1) then C(26'h4).
//      -> pair_count=1; front_in A -> front_out 26'h4; rear_in C -> rear_out 26'h1; front_in B unchanged.
//   3. Rejections, each followed by a check that the FSM is back in P_FIRST and the table is unchanged:
//      - A then A -> prog_error pulse.
//      - with A-C plugged, offer C -> prog_error pulse.
//      - offer 26'h3 -> prog_error pulse.
//   4. Program 10 disjoint pairs -> pair_count=10, prog_ready=0; an 11th prog_valid gives no change and no error.
//      Then prog_clear together with prog_valid -> pair_count=0, identity mapping, no prog_error.
//   5. Same-edge hazard: issue front_in=A in the cycle the second letter of pair A-B commits -> front_out=A. The next lookup gives B.
//   6. Assert reset after only the first letter is accepted -> on release: FSM=P_FIRST, pair_count=0, all lookups identity.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared letter types and one-hot helpers for the Enigma datapath.
package enigma_pkg;
  localparam int N_LETTERS = 26;
  localparam int MAX_PAIRS = 10;

  typedef logic [N_LETTERS-1:0] letter_oh_t;
  typedef logic [4:0]           letter_idx_t;

  typedef enum logic [1:0] {P_FIRST, P_SECOND, P_FULL} prog_state_t;

  function automatic logic is_onehot(letter_oh_t v);
    return (v != '0) && ((v & (v - letter_oh_t'(1))) == '0);
  endfunction

  // Lowest set bit wins; only meaningful for one-hot inputs.
  function automatic letter_idx_t oh2idx(letter_oh_t v);
    letter_idx_t r;
    r = '0;
    for (int i = N_LETTERS - 1; i >= 0; i--)
      if (v[i]) r = letter_idx_t'(i);
    return r;
  endfunction

  function automatic letter_oh_t idx2oh(letter_idx_t idx);
    return letter_oh_t'(1) << idx;
  endfunction
endpackage

// File: rtl/letter_swap.sv
// Combinational plugboard swap: one-hot letter through the partner/plugged table.
// Non-one-hot input produces all-zero output.
module letter_swap
  import enigma_pkg::*;
(
  input  logic [N_LETTERS-1:0]                  letter_in,
  input  logic [N_LETTERS-1:0][4:0]             partner,
  input  logic [N_LETTERS-1:0]                  plugged,
  output logic [N_LETTERS-1:0]                  letter_out
);
  letter_idx_t idx;

  always_comb begin
    idx        = oh2idx(letter_in);
    letter_out = '0;
    if (is_onehot(letter_in)) begin
      if (plugged[idx]) letter_out = idx2oh(partner[idx]);
      else              letter_out = letter_in;
    end
  end
endmodule

// File: rtl/plugboard_mapper.sv
// Enigma plugboard: letter-pair programming FSM, swap table and two registered lookup ports.
// Lookups take one cycle and always see the table as it was before the current edge.
module plugboard_mapper
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS_P = MAX_PAIRS
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 prog_valid,
  input  logic [N_LETTERS-1:0] prog_letter,
  output logic                 prog_ready,
  input  logic                 prog_clear,
  output logic                 prog_error,
  output logic [3:0]           pair_count,
  input  logic                 front_valid,
  input  logic [N_LETTERS-1:0] front_in,
  output logic                 front_out_valid,
  output logic [N_LETTERS-1:0] front_out,
  input  logic                 rear_valid,
  input  logic [N_LETTERS-1:0] rear_in,
  output logic                 rear_out_valid,
  output logic [N_LETTERS-1:0] rear_out
);
  prog_state_t                  state;
  letter_idx_t                  first_idx;
  logic [N_LETTERS-1:0][4:0]    partner;
  logic [N_LETTERS-1:0]         plugged;

  logic                         accept;
  logic                         letter_ok;
  letter_idx_t                  letter_idx;
  logic [N_LETTERS-1:0]         front_swapped;
  logic [N_LETTERS-1:0]         rear_swapped;

  assign prog_ready = (state != P_FULL);

  // The one-hot term gates the other two, so letter_idx is only trusted when it is valid.
  always_comb begin
    accept     = prog_valid & prog_ready;
    letter_idx = oh2idx(prog_letter);
    letter_ok  = is_onehot(prog_letter)
              && ((prog_letter & plugged) == '0)
              && !((state == P_SECOND) && (letter_idx == first_idx));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= P_FIRST;
      first_idx  <= '0;
      partner    <= '0;
      plugged    <= '0;
      pair_count <= '0;
      prog_error <= 1'b0;
    end else begin
      prog_error <= 1'b0;
      if (prog_clear) begin
        partner    <= '0;
        plugged    <= '0;
        pair_count <= '0;
        state      <= P_FIRST;
      end else if (accept) begin
        if (!letter_ok) begin
          prog_error <= 1'b1;
          state      <= P_FIRST;
        end else if (state == P_FIRST) begin
          first_idx <= letter_idx;
          state     <= P_SECOND;
        end else begin
          partner[first_idx]  <= letter_idx;
          partner[letter_idx] <= first_idx;
          plugged             <= plugged | prog_letter | idx2oh(first_idx);
          pair_count          <= pair_count + 4'd1;
          state <= (pair_count == 4'(MAX_PAIRS_P - 1)) ? P_FULL : P_FIRST;
        end
      end
    end
  end

  letter_swap u_front_swap (
    .letter_in  (front_in),
    .partner    (partner),
    .plugged    (plugged),
    .letter_out (front_swapped)
  );

  letter_swap u_rear_swap (
    .letter_in  (rear_in),
    .partner    (partner),
    .plugged    (plugged),
    .letter_out (rear_swapped)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      front_out_valid <= 1'b0;
      front_out       <= '0;
      rear_out_valid  <= 1'b0;
      rear_out        <= '0;
    end else begin
      front_out_valid <= front_valid;
      rear_out_valid  <= rear_valid;
      if (front_valid) front_out <= front_swapped;
      if (rear_valid)  rear_out  <= rear_swapped;
    end
  end
endmodule

// File: tb/tb_plugboard_mapper.sv
// Directed bench for plugboard_mapper with a lookup scoreboard and a small swap model.
module tb_plugboard_mapper;
  logic        CLOCK_50;
  logic        reset;
  logic        prog_valid;
  logic [25:0] prog_letter;
  logic        prog_ready;
  logic        prog_clear;
  logic        prog_error;
  logic [3:0]  pair_count;
  logic        front_valid;
  logic [25:0] front_in;
  logic        front_out_valid;
  logic [25:0] front_out;
  logic        rear_valid;
  logic [25:0] rear_in;
  logic        rear_out_valid;
  logic [25:0] rear_out;

  int total = 0;
  int bad   = 0;
  int mp[26];
  logic [25:0] fq[$];
  logic [25:0] rq[$];

  plugboard_mapper dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .prog_valid      (prog_valid),
    .prog_letter     (prog_letter),
    .prog_ready      (prog_ready),
    .prog_clear      (prog_clear),
    .prog_error      (prog_error),
    .pair_count      (pair_count),
    .front_valid     (front_valid),
    .front_in        (front_in),
    .front_out_valid (front_out_valid),
    .front_out       (front_out),
    .rear_valid      (rear_valid),
    .rear_in         (rear_in),
    .rear_out_valid  (rear_out_valid),
    .rear_out        (rear_out)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [25:0] L(int i);
    logic [25:0] one;
    one = 26'd1;
    return one << i;
  endfunction

  function automatic logic [25:0] swap_m(logic [25:0] v);
    if ($countones(v) != 1) return 26'd0;
    for (int i = 0; i < 26; i++)
      if (v[i]) return L(mp[i]);
    return 26'd0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 26; i++) mp[i] = i;
  endtask

  task automatic m_pair(int a, int b);
    mp[a] = b;
    mp[b] = a;
  endtask

  task automatic chk(string tag, logic [25:0] obs, logic [25:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard for every lookup issued before the last edge.
  task automatic drain();
    if (fq.size() > 0) begin
      chk("front_out_valid", 26'(front_out_valid), 26'd1);
      chk("front_out", front_out, fq.pop_front());
    end else begin
      chk("front_out_valid_idle", 26'(front_out_valid), 26'd0);
    end
    if (rq.size() > 0) begin
      chk("rear_out_valid", 26'(rear_out_valid), 26'd1);
      chk("rear_out", rear_out, rq.pop_front());
    end else begin
      chk("rear_out_valid_idle", 26'(rear_out_valid), 26'd0);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    prog_valid  = 1'b0;
    prog_clear  = 1'b0;
    front_valid = 1'b0;
    rear_valid  = 1'b0;
    drain();
  endtask

  task automatic look_front(logic [25:0] l);
    front_valid = 1'b1;
    front_in    = l;
    fq.push_back(swap_m(l));
  endtask

  task automatic look_rear(logic [25:0] l);
    rear_valid = 1'b1;
    rear_in    = l;
    rq.push_back(swap_m(l));
  endtask

  task automatic prog(logic [25:0] l);
    prog_valid  = 1'b1;
    prog_letter = l;
    tick();
  endtask

  task automatic prog_pair(int a, int b, int exp_cnt);
    prog(L(a));
    chk("err_first", 26'(prog_error), 26'd0);
    prog(L(b));
    chk("err_second", 26'(prog_error), 26'd0);
    m_pair(a, b);
    chk("pair_count", 26'(pair_count), 26'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1;
    prog_valid = 1'b0; prog_letter = '0; prog_clear = 1'b0;
    front_valid = 1'b0; front_in = '0; rear_valid = 1'b0; rear_in = '0;
    m_clear();
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;

    // 1. reset state and identity lookup
    chk("rst_pair_count", 26'(pair_count), 26'd0);
    chk("rst_prog_error", 26'(prog_error), 26'd0);
    chk("rst_prog_ready", 26'(prog_ready), 26'd1);
    chk("rst_front_out", front_out, 26'd0);
    chk("rst_rear_out", rear_out, 26'd0);
    drain();
    look_front(26'h1);
    tick();
    chk("id_pair_count", 26'(pair_count), 26'd0);

    // 2. A-C pair
    prog_pair(0, 2, 1);
    look_front(L(0)); look_rear(L(2)); tick();
    chk("model_A_to_C", swap_m(L(0)), 26'h4);
    look_front(L(1)); look_rear(26'h3); tick();
    tick();
    chk("front_hold", front_out, 26'h2);
    chk("rear_hold", rear_out, 26'h0);

    // 3a. same letter twice
    prog(L(4));
    chk("E_first_err", 26'(prog_error), 26'd0);
    prog(L(4));
    chk("EE_err", 26'(prog_error), 26'd1);
    chk("EE_count", 26'(pair_count), 26'd1);
    tick();
    chk("err_pulse_one_cycle", 26'(prog_error), 26'd0);
    prog(L(5));
    chk("after_EE_first_no_commit", 26'(pair_count), 26'd1);
    prog(L(6));
    m_pair(5, 6);
    chk("after_EE_pair", 26'(pair_count), 26'd2);
    look_front(L(5)); look_rear(L(4)); tick();

    // 3b. already plugged letter
    prog(L(2));
    chk("plugged_err", 26'(prog_error), 26'd1);
    prog(L(7));
    chk("after_plugged_first", 26'(pair_count), 26'd2);
    prog(L(8));
    m_pair(7, 8);
    chk("after_plugged_pair", 26'(pair_count), 26'd3);

    // 3c. not one-hot
    prog(26'h3);
    chk("multi_hot_err", 26'(prog_error), 26'd1);
    prog(26'h0);
    chk("zero_hot_err", 26'(prog_error), 26'd1);
    prog_pair(9, 10, 4);
    look_front(L(0)); look_rear(L(10)); tick();
    look_front(L(4)); look_rear(L(7)); tick();

    // 4. fill to MAX_PAIRS
    prog_pair(11, 12, 5);
    prog_pair(13, 14, 6);
    prog_pair(15, 16, 7);
    prog_pair(17, 18, 8);
    prog_pair(19, 20, 9);
    chk("ready_before_full", 26'(prog_ready), 26'd1);
    prog_pair(21, 22, 10);
    chk("full_ready", 26'(prog_ready), 26'd0);
    prog(L(23));
    chk("full_ignore_err", 26'(prog_error), 26'd0);
    chk("full_ignore_count", 26'(pair_count), 26'd10);
    look_front(L(23)); look_rear(L(21)); tick();
    prog_clear = 1'b1; prog_valid = 1'b1; prog_letter = L(24);
    tick();
    m_clear();
    chk("clear_count", 26'(pair_count), 26'd0);
    chk("clear_err", 26'(prog_error), 26'd0);
    chk("clear_ready", 26'(prog_ready), 26'd1);
    look_front(L(0)); look_rear(L(21)); tick();

    // clear wins over an accepted letter in P_FIRST too
    prog_clear = 1'b1; prog_valid = 1'b1; prog_letter = L(3);
    tick();
    prog(L(3));
    chk("clear_drop_no_commit", 26'(pair_count), 26'd0);
    chk("clear_drop_no_err", 26'(prog_error), 26'd0);
    prog_clear = 1'b1;
    tick();

    // 5. lookup on the commit edge sees the old table
    prog(L(0));
    look_front(L(0));
    prog_valid = 1'b1; prog_letter = L(1);
    tick();
    m_pair(0, 1);
    chk("hazard_count", 26'(pair_count), 26'd1);
    look_front(L(0)); look_rear(L(1)); tick();

    // 6. reset with only a first letter latched
    prog(L(2));
    chk("pre_reset_count", 26'(pair_count), 26'd1);
    reset = 1'b1;
    #2;
    chk("async_rst_count", 26'(pair_count), 26'd0);
    chk("async_rst_fvalid", 26'(front_out_valid), 26'd0);
    chk("async_rst_front_out", front_out, 26'd0);
    reset = 1'b0;
    m_clear();
    look_front(L(0)); look_rear(L(1)); tick();
    prog(L(3));
    chk("post_reset_first_only", 26'(pair_count), 26'd0);
    prog(L(4));
    m_pair(3, 4);
    chk("post_reset_pair", 26'(pair_count), 26'd1);
    look_front(L(2)); look_rear(L(4)); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
